// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register: PC, one-cycle imem latency, stall skid buffer, redirects.
// Optional FETCH_PERF_EN adds stall_cycles / redirect_count performance counters.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCAddResultOut,
  output logic [31:0] InstructionOut,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] resp_pc, resp_pc_nxt;
  logic        resp_valid, resp_valid_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic        hold_valid, hold_valid_nxt;
  logic        misalign_nxt;
  logic        req_c;
  logic [31:0] redir_addr;

  assign redir_addr = {redirect_target[31:2], 2'b00};
  // BOOT drives a request, but nothing may leave the block while reset is held
  assign imem_req   = req_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      fetch_pc     <= PC_RESET;
      resp_pc      <= '0;
      resp_valid   <= 1'b0;
      hold_instr   <= '0;
      hold_pc      <= '0;
      hold_valid   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      resp_pc      <= resp_pc_nxt;
      resp_valid   <= resp_valid_nxt;
      hold_instr   <= hold_instr_nxt;
      hold_pc      <= hold_pc_nxt;
      hold_valid   <= hold_valid_nxt;
      misalign_err <= misalign_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    resp_pc_nxt    = resp_pc;
    resp_valid_nxt = 1'b0;
    hold_instr_nxt = hold_instr;
    hold_pc_nxt    = hold_pc;
    hold_valid_nxt = hold_valid;
    misalign_nxt   = misalign_err;
    req_c          = 1'b0;
    imem_addr      = fetch_pc;
    ifid_write     = 1'b0;
    ifid_flush     = 1'b0;
    InstructionOut = '0;
    PCAddResultOut = '0;
    case (state)
      BOOT: begin
        req_c          = 1'b1;
        resp_valid_nxt = 1'b1;
        resp_pc_nxt    = fetch_pc;
        fetch_pc_nxt   = fetch_pc + 32'd4;
        state_nxt      = RUN;
      end
      default: begin
        if (redirect) begin
          ifid_flush     = 1'b1;
          req_c          = 1'b1;
          imem_addr      = redir_addr;
          resp_valid_nxt = 1'b1;
          resp_pc_nxt    = redir_addr;
          fetch_pc_nxt   = redir_addr + 32'd4;
          hold_valid_nxt = 1'b0;
          state_nxt      = RUN;
          if (redirect_target[1:0] != 2'b00) misalign_nxt = 1'b1;
        end else if (stall) begin
          if (resp_valid) begin
            hold_valid_nxt = 1'b1;
            hold_instr_nxt = imem_rdata;
            hold_pc_nxt    = resp_pc;
          end
          state_nxt = STALL;
        end else begin
          // A STALL cycle with stall released already behaves as RUN, so a k-cycle stall costs k bubbles
          if (hold_valid) begin
            ifid_write     = 1'b1;
            InstructionOut = hold_instr;
            PCAddResultOut = hold_pc + 32'd4;
            hold_valid_nxt = 1'b0;
          end else if (resp_valid) begin
            ifid_write     = 1'b1;
            InstructionOut = imem_rdata;
            PCAddResultOut = resp_pc + 32'd4;
          end
          req_c          = 1'b1;
          resp_valid_nxt = 1'b1;
          resp_pc_nxt    = fetch_pc;
          fetch_pc_nxt   = fetch_pc + 32'd4;
          state_nxt      = RUN;
        end
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else if (state != BOOT) begin
      if (stall)    stall_cycles   <= stall_cycles + 32'd1;
      if (redirect) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan scenarios plus randomized stall/redirect/reset
// traffic checked every cycle against a PC-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] PCAddResultOut;
  logic [31:0] InstructionOut;
  logic        ifid_write;
  logic        ifid_flush;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] redirect_count;
`endif

  fetch_unit #(.PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .PCAddResultOut(PCAddResultOut), .InstructionOut(InstructionOut),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
    , .stall_cycles(stall_cycles), .redirect_count(redirect_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned fails = 0;
  logic [31:0] mem_xor = '0;

  // Synchronous memory: word at address a is a ^ mem_xor; idle cycles return junk
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ mem_xor;
    else          imem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the PC of the next instruction IF/ID must receive, plus a boot flag and sticky error
  logic        m_boot = 1'b1;
  logic [31:0] m_pc = '0;
  logic        m_mis = 1'b0;
  logic [31:0] m_sc = '0;
  logic [31:0] m_rc = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_write", {31'd0, ifid_write}, 32'd0);
      chk("rst_flush", {31'd0, ifid_flush}, 32'd0);
      chk("rst_pcadd", PCAddResultOut, 32'd0);
      chk("rst_instr", InstructionOut, 32'd0);
      chk("rst_mis", {31'd0, misalign_err}, 32'd0);
      m_boot = 1'b1; m_pc = 32'h0; m_mis = 1'b0; m_sc = '0; m_rc = '0;
    end else begin
      chk("mis", {31'd0, misalign_err}, {31'd0, m_mis});
`ifdef FETCH_PERF_EN
      chk("stall_cycles", stall_cycles, m_sc);
      chk("redirect_count", redirect_count, m_rc);
`endif
      if (m_boot) begin
        chk("boot_req", {31'd0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr, m_pc);
        chk("boot_write", {31'd0, ifid_write}, 32'd0);
        chk("boot_flush", {31'd0, ifid_flush}, 32'd0);
        m_boot = 1'b0;
      end else if (redirect) begin
        chk("rd_flush", {31'd0, ifid_flush}, 32'd1);
        chk("rd_write", {31'd0, ifid_write}, 32'd0);
        chk("rd_req", {31'd0, imem_req}, 32'd1);
        chk("rd_addr", imem_addr, redirect_target & 32'hFFFF_FFFC);
        m_pc = redirect_target & 32'hFFFF_FFFC;
        if (redirect_target % 4 != 0) m_mis = 1'b1;
        m_rc++;
        if (stall) m_sc++;
      end else if (stall) begin
        chk("st_write", {31'd0, ifid_write}, 32'd0);
        chk("st_flush", {31'd0, ifid_flush}, 32'd0);
        chk("st_req", {31'd0, imem_req}, 32'd0);
        m_sc++;
      end else begin
        chk("run_write", {31'd0, ifid_write}, 32'd1);
        chk("run_flush", {31'd0, ifid_flush}, 32'd0);
        chk("run_instr", InstructionOut, m_pc ^ mem_xor);
        chk("run_pcadd", PCAddResultOut, m_pc + 32'd4);
        chk("run_req", {31'd0, imem_req}, 32'd1);
        chk("run_addr", imem_addr, m_pc + 32'd4);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic step(input logic s, input logic r, input logic [31:0] t);
    @(posedge clk);
    #1;
    stall = s; redirect = r; redirect_target = t;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    release_reset();
    chk("L_boot_write", {31'd0, ifid_write}, 32'd0);
    chk("L_boot_addr", imem_addr, 32'h0);
    step(0, 0, 0); chk("L_i0", InstructionOut, 32'h0); chk("L_p0", PCAddResultOut, 32'h4);
    step(0, 0, 0); chk("L_i4", InstructionOut, 32'h4); chk("L_p4", PCAddResultOut, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0); chk("L_stall_write", {31'd0, ifid_write}, 32'd0);
    end
    step(0, 0, 0); chk("L_i8", InstructionOut, 32'h8); chk("L_p8", PCAddResultOut, 32'hC);
    step(0, 0, 0); chk("L_iC", InstructionOut, 32'hC); chk("L_wC", {31'd0, ifid_write}, 32'd1);
    step(0, 1, 32'h100); chk("L_flush", {31'd0, ifid_flush}, 32'd1);
    step(0, 0, 0); chk("L_i100", InstructionOut, 32'h100); chk("L_p100", PCAddResultOut, 32'h104);
    step(1, 1, 32'h40); chk("L_sr_flush", {31'd0, ifid_flush}, 32'd1);
    step(0, 0, 0); chk("L_i40", InstructionOut, 32'h40); chk("L_w40", {31'd0, ifid_write}, 32'd1);
    step(0, 1, 32'h203); chk("L_a200", imem_addr, 32'h200);
    step(0, 0, 0); chk("L_i200", InstructionOut, 32'h200); chk("L_mis1", {31'd0, misalign_err}, 32'd1);
    step(0, 1, 32'h300);
    step(0, 0, 0); chk("L_i300", InstructionOut, 32'h300); chk("L_mis2", {31'd0, misalign_err}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
    #1;
    chk("L_rst_write", {31'd0, ifid_write}, 32'd0);
    chk("L_rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("L_rst_pcadd", PCAddResultOut, 32'd0);
    release_reset();
    chk("L_reboot_addr", imem_addr, 32'h0);
    step(0, 0, 0); chk("L_ri0", InstructionOut, 32'h0); chk("L_rp0", PCAddResultOut, 32'h4);

    // Random traffic, including wrap-around targets and occasional resets with new memory contents
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(249) == 0) begin
        @(posedge clk);
        #1;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
        mem_xor = $urandom;
        release_reset();
      end else begin
        logic [31:0] t;
        case ($urandom_range(3))
          0:       t = 32'hFFFF_FFF0 | ($urandom & 32'hC);
          1:       t = $urandom;
          default: t = $urandom & 32'h0000_FFFC;
        endcase
        if ($urandom_range(15) == 0) t[1:0] = 2'($urandom_range(3));
        step($urandom_range(3) == 0, $urandom_range(7) == 0, t);
      end
    end
    @(posedge clk);
    #1;
    stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
